fp_result_fifo: RTL
===================

Name: fp_result_fifo

Overview:
- Elastic, non-transparent FIFO placed directly downstream of the floating-point multiplier's result port (result/result_valid/result_ready).
- Absorbs multiplier results so that downstream back-pressure does not immediately drop the multiplier's ready and freeze its pipeline clock-enable.
- Uses the same valid/ready dataflow handshake as the rest of the arithmetic units. Depth and data width are parameters.

Parameters:
- DATA_WIDTH, 32, width of each stored word (IEEE-754 single by default).
- NUM_SLOTS, 4, FIFO depth in words. Must be at least 2; need not be a power of two.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- ins  input  DATA_WIDTH  write data from the multiplier result.
- ins_valid  input  1  write data valid.
- ins_ready  output  1  FIFO can accept a word this cycle.
- outs  output  DATA_WIDTH  head-of-queue data.
- outs_valid  output  1  head-of-queue data valid.
- outs_ready  input  1  consumer accepts the head word.
- count  output  $clog2(NUM_SLOTS+1)  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - head=0, tail=0, count=0.
  - outs_valid=0, ins_ready=1 as soon as rst is released.
  - Storage contents are not reset.
  - outs is don't-care while outs_valid=0; the bench must not check it.
- Reset mid-operation: all stored words are discarded. No output is produced from pre-reset data after rst returns to 1.
- push = ins_valid & ins_ready. pop = outs_valid & outs_ready.
- ins_ready = (count != NUM_SLOTS). It is registered-derived and has no combinational path from outs_ready. A full FIFO does not accept a word in the same cycle as a pop.
- outs_valid = (count != 0). outs = mem[head], read combinationally from the storage registers.
- On push: mem[tail] <= ins; tail advances.
- On pop: head advances.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 wraps to 0. Comparison is explicit, not modulo-2^n, so non-power-of-two depths are legal.
- count next-state:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both or neither.
- Simultaneous push and pop with 0<count<NUM_SLOTS: both happen; count is unchanged.
- Empty: no bypass. A word written in cycle N appears on outs with outs_valid=1 in cycle N+1 at the earliest (minimum latency 1 cycle).
- Full: ins_ready=0 and ins is ignored. Pop alone brings count to NUM_SLOTS-1, and ins_ready=1 in the next cycle.
- Throughput: 1 word/cycle sustained whenever 0<count<NUM_SLOTS.
- Ordering: strict FIFO. No word is duplicated or lost.
- Held data: outs and outs_valid stay stable while outs_valid=1 and outs_ready=0.
- State machine (derived from count): EMPTY (count=0), PARTIAL, FULL (count=NUM_SLOTS).
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop when count=NUM_SLOTS-1.
  - PARTIAL -> EMPTY on pop without push when count=1.
  - FULL -> PARTIAL on pop.
  - All other cases stay in the current state.

Decomposition:
- No shared package needed.
- Local constants: PTR_W = $clog2(NUM_SLOTS), CNT_W = $clog2(NUM_SLOTS+1).
- One natural sub-module: fifo_ptr_ctrl. It holds the head/tail/count registers, wrap logic and the full/empty flags. The top level keeps the storage array and the data mux.

Test Plan:
- Reset release, no stimulus -> ins_ready=1, outs_valid=0, count=0.
- NUM_SLOTS=4, outs_ready=0, push 0x3F800000, 0x40000000, 0x40400000, 0x40800000 -> count=4, ins_ready=0.
  - A fifth push with 0x40A00000 is ignored.
  - outs=0x3F800000 with outs_valid=1.
- Full FIFO, outs_ready=1 and ins_valid=1 with 0x40A00000 for 1 cycle -> only the pop occurs; count=3.
  - Next cycle: ins_ready=1, outs=0x40000000.
- Empty FIFO, push 0x12345678 at cycle N with outs_ready=1 -> outs_valid=0 at cycle N; outs=0x12345678 with outs_valid=1 at N+1; count back to 0 at N+2.
- NUM_SLOTS=3, 10 continuous push/pop cycles of an incrementing pattern -> output sequence identical to the input sequence; count constant at 1; pointers wrap through 2->0.
- Load 2 words, then drive rst=0 asynchronously mid-cycle -> outs_valid=0 and count=0 immediately, with no clock edge needed; no stale word is emitted after release.

Source files
------------

// File: rtl/fp_result_fifo_pkg.sv
// Shared types for the multiplier result FIFO.
package fp_result_fifo_pkg;

  // Occupancy state; the encoding doubles as {ins_ready, outs_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b10,
    ST_PARTIAL = 2'b11,
    ST_FULL    = 2'b01
  } fifo_state_e;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping and occupancy flags for fp_result_fifo.
module fifo_ptr_ctrl
  import fp_result_fifo_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  localparam int unsigned PTR_W = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  input  logic             outs_ready,
  output logic             ins_ready,
  output logic             outs_valid,
  output logic             wr_en_c,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_state_e      state_q, state_d;
  logic             push_c, pop_c;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers, occupancy and flags.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    push_c  = ins_valid & state_q[1];
    pop_c   = state_q[0] & outs_ready;
    if (push_c) tail_d = ptr_inc(tail_q);
    if (pop_c)  head_d = ptr_inc(head_q);
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)                        state_d = ST_EMPTY;
    else if (count_d == CNT_W'(NUM_SLOTS))    state_d = ST_FULL;
    else                                      state_d = ST_PARTIAL;
  end

  // State registers; reset discards all stored words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign ins_ready  = state_q[1];
  assign outs_valid = state_q[0];
  assign wr_en_c    = push_c;
  assign head       = head_q;
  assign tail       = tail_q;
  assign count      = count_q;

endmodule

// File: rtl/fp_result_fifo.sv
// Elastic non-transparent FIFO behind the FP multiplier result port.
module fp_result_fifo
  import fp_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          ins,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  output logic [DATA_WIDTH-1:0]          outs,
  output logic                           outs_valid,
  input  logic                           outs_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [PTR_W-1:0]      head, tail;
  logic                  wr_en_c;

  fifo_ptr_ctrl #(.NUM_SLOTS(NUM_SLOTS)) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .outs_ready (outs_ready),
    .ins_ready  (ins_ready),
    .outs_valid (outs_valid),
    .wr_en_c    (wr_en_c),
    .head       (head),
    .tail       (tail),
    .count      (count)
  );

  // Storage array; contents intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[tail] <= ins;
  end

  assign outs = mem_q[head];

endmodule
